// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. Bytes pushed by the CPU's memory stage are queued in
// a FIFO and drained onto the serial line by a baud-rate FSM, back to back with no idle gap.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset; aborts any frame and discards queued data
//   wr_en    single-cycle push strobe
//   wr_data  byte to push (bits above DATA_BITS-1 ignored)
//   clr_ovf  clears the sticky overflow flag (a same-edge dropped push wins)
//   full     FIFO holds FIFO_DEPTH entries
//   empty    FIFO holds no entries
//   count    FIFO occupancy
//   ovf      sticky: a push was dropped because the FIFO was full
//   tx_busy  FSM is not idle
//   uart_tx  registered serial line, idles high
//
// Optional feature: define UART_TX_PARITY_EN to append an even-parity bit after the data bits.

module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   input  logic                          clr_ovf,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          ovf,
   output logic                          tx_busy,
   output logic                          uart_tx
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);
   localparam int unsigned DW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [DW-1:0] BIT_LAST  = DW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        count_q;
   logic                 ovf_q;
   state_e               state_q, state_d;
   logic [BW-1:0]        baud_q;
   logic [DW-1:0]        bit_q;
   logic                 stop_q;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 push, drop, pop, baud_last, has_data;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   // FIFO status comes from the occupancy counter, so full/empty never alias on pointer wrap.
   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign has_data  = !empty;
   assign push      = wr_en && !full;
   assign drop      = wr_en && full;
   assign baud_last = (baud_q == BAUD_LAST);

   assign count   = count_q;
   assign ovf     = ovf_q;
   assign tx_busy = (state_q != StIdle);
   assign uart_tx = tx_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wr_data[DATA_BITS-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         if (drop)         ovf_q <= 1'b1;
         else if (clr_ovf) ovf_q <= 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (has_data) state_d = StStart;
         StStart: if (baud_last) state_d = StData;
         StData: begin
            if (baud_last && (bit_q == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
               state_d = StParity;
`else
               state_d = StStop;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: if (baud_last) state_d = StStop;
`endif
         StStop: begin
            // Chain straight into the next frame when data is waiting.
            if (baud_last && (stop_q == STOP_LAST)) state_d = has_data ? StStart : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs: pop, next shift contents and next line level
   always_comb begin
      pop     = (state_d == StStart) && ((state_q == StIdle) || (state_q == StStop));
      shift_d = shift_q;
      if (pop)                             shift_d = mem[rd_ptr_q];
      else if ((state_q == StData) && baud_last) shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
      parity_d = pop ? ^mem[rd_ptr_q] : parity_q;
`endif
      tx_d = 1'b1;
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = parity_q;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_q   <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         shift_q <= shift_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
         if ((state_q == StIdle) || baud_last) baud_q <= '0;
         else                                  baud_q <= baud_q + 1'b1;
         if (state_q != StData) bit_q <= '0;
         else if (baud_last)    bit_q <= bit_q + 1'b1;
         if (state_q != StStop) stop_q <= 1'b0;
         else if (baud_last)    stop_q <= ~stop_q;
      end
   end

endmodule
